// File: rtl/dram_axi_master.sv
// Single-outstanding AXI-style master turning 13-bit word commands into AR/R or AW/W/B bursts of one beat.
// Optional watchdog: define DRAM_TIMEOUT_EN to abort any channel wait after TIMEOUT_CYC cycles.
module dram_axi_master #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_rd,
  input  logic [12:0] in_addr,
  input  logic [63:0] in_wdata,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic        AR_VALID,
  output logic [31:0] AR_ADDR,
  input  logic        AR_READY,
  input  logic        R_VALID,
  input  logic [63:0] R_DATA,
  input  logic [1:0]  R_RESP,
  output logic        R_READY,
  output logic        AW_VALID,
  output logic [31:0] AW_ADDR,
  input  logic        AW_READY,
  output logic        W_VALID,
  output logic [63:0] W_DATA,
  input  logic        W_READY,
  input  logic        B_VALID,
  input  logic [1:0]  B_RESP,
  output logic        B_READY
);

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] data_q, data_d;
  logic        err_q, err_d;
  // Holds in_ready low until the first clock after reset release.
  logic        live_q;
  logic        in_chan;

  assign in_chan = (state_q == S_AR) || (state_q == S_R) || (state_q == S_AW) ||
                   (state_q == S_W)  || (state_q == S_B);

`ifdef DRAM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      // Direction is carried by the AR/AW branch taken, so no separate rd flag is kept.
      S_IDLE: if (in_valid && live_q) begin
        addr_d  = in_addr;
        wdata_d = in_wdata;
        state_d = in_rd ? S_AR : S_AW;
      end
      S_AR: if (AR_READY) state_d = S_R;
      S_R: if (R_VALID) begin
        data_d  = R_DATA;
        err_d   = |R_RESP;
        state_d = S_DONE;
      end
      S_AW: if (AW_READY) state_d = S_W;
      S_W:  if (W_READY)  state_d = S_B;
      S_B: if (B_VALID) begin
        data_d  = '0;
        err_d   = |B_RESP;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`ifdef DRAM_TIMEOUT_EN
    // A handshake on the final allowed cycle still wins over the timeout.
    if (in_chan && (state_d == state_q) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
      state_d = S_DONE;
      data_d  = '0;
      err_d   = 1'b1;
    end
    cnt_d = (in_chan && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

`ifdef DRAM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign in_ready  = (state_q == S_IDLE) && live_q;
  assign AR_VALID  = (state_q == S_AR);
  assign AR_ADDR   = {19'b0, addr_q};
  assign R_READY   = (state_q == S_R);
  assign AW_VALID  = (state_q == S_AW);
  assign AW_ADDR   = {19'b0, addr_q};
  assign W_VALID   = (state_q == S_W);
  assign W_DATA    = wdata_q;
  assign B_READY   = (state_q == S_B);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;
  assign out_err   = err_q;

endmodule

// File: doc/dram_axi_master.md
DRAM_AXI_MASTER -- requirements
Module: dram_axi_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 1023, meaning the maximum cycles spent waiting in one channel state; it SHALL be used only when DRAM_TIMEOUT_EN is defined.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid&in_ready.
- in_rd  in  1  1=read, 0=write.
- in_addr  in  13  DRAM word index 0..8191.
- in_wdata  in  64  write data.
- out_valid  out  1  one-cycle completion pulse.
- out_data  out  64  read data; 0 for writes.
- out_err  out  1  response error flag, valid with out_valid.
- AR_VALID / AR_ADDR / AR_READY  out / out / in  1 / 32 / 1  read address channel.
- R_VALID / R_DATA / R_RESP / R_READY  in / in / in / out  1 / 64 / 2 / 1  read data channel.
- AW_VALID / AW_ADDR / AW_READY  out / out / in  1 / 32 / 1  write address channel.
- W_VALID / W_DATA / W_READY  out / out / in  1 / 64 / 1  write data channel.
- B_VALID / B_RESP / B_READY  in / in / out  1 / 2 / 1  write response channel.

Function
REQ-003 The FSM SHALL have states IDLE, AR, R, AW, W, B, DONE; in_ready SHALL be 1 only in IDLE.
REQ-004 On in_valid&in_ready, the block SHALL register in_rd/in_addr/in_wdata and move to AR (read) or AW (write); AR_ADDR/AW_ADDR SHALL be {19'b0, addr}.
REQ-005 In AR, AR_VALID SHALL be 1 with stable AR_ADDR until the cycle AR_VALID&AR_READY, then move to R.
REQ-006 In R, R_READY SHALL be 1; on R_VALID&R_READY, the block SHALL capture R_DATA and out_err=|R_RESP, then move to DONE.
REQ-007 In AW, AW_VALID SHALL be 1 until AW_VALID&AW_READY, then move to W.
REQ-008 In W, W_VALID SHALL be 1 with W_DATA=registered wdata until W_VALID&W_READY, then move to B.
REQ-009 In B, B_READY SHALL be 1; on B_VALID, out_err=|B_RESP, out_data=0, then move to DONE; B_VALID outside B SHALL be ignored.
REQ-010 In DONE, out_valid SHALL be 1 for exactly one cycle, then return to IDLE; out_data/out_err SHALL hold until the next DONE.
REQ-011 A handshake completing in the first cycle of a state SHALL advance the state in the next cycle; minimum latency from command acceptance to out_valid SHALL be 3 cycles for a read and 4 cycles for a write.
REQ-012 No VALID output SHALL deassert before its handshake completes, except at reset or timeout.

Reset
REQ-013 rst_n low SHALL asynchronously force IDLE and drive all outputs to 0 (in_ready becomes 1 after release), aborting any in-flight transfer without out_valid.

Configuration
REQ-014 With DRAM_TIMEOUT_EN defined, a counter SHALL clear on every state entry; reaching TIMEOUT_CYC in AR/R/AW/W/B SHALL deassert channel signals and go to DONE with out_err=1, out_data=0.
REQ-015 Without DRAM_TIMEOUT_EN, there SHALL be no counter, and the block SHALL wait indefinitely in every state.

Verification
REQ-016 Write addr=5, data=64'hDEAD_BEEF_0123_4567, slave readies in 1 cycle, B_RESP=0 -> AW_ADDR=5, W_DATA matches, out_valid once, out_err=0.
REQ-017 Read addr=5 after REQ-016 -> AR_ADDR=5, out_data=64'hDEAD_BEEF_0123_4567, out_err=0, latency 3 cycles with zero-wait slave.
REQ-018 Read addr=8191 with R_RESP=2'b10, AR_READY delayed 7 cycles -> AR_VALID held 8 cycles, out_err=1.
REQ-019 rst_n asserted while in W -> W_VALID=0 immediately, no out_valid, in_ready=1 after release.
REQ-020 With DRAM_TIMEOUT_EN and TIMEOUT_CYC=16, AW_READY never asserted -> out_valid after 16 cycles in AW, out_err=1.
